// File: rtl/serial_frame_receiver_pkg.sv
// Shared types and constants for the tick-paced serial frame receiver.
package serial_frame_receiver_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StArmed = 2'd1,
    StShift = 2'd2
  } state_e;

  localparam int unsigned DefaultWidth = 16;
  localparam bit          MsbFirst     = 1'b1;

endpackage

// File: rtl/sfr_shift_reg.sv
// Tick-gated shift register; pdata is the word including the bit being shifted in this cycle.
module sfr_shift_reg
  import serial_frame_receiver_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tick,
  input  logic             en,
  input  logic             clr,
  input  logic             din,
  output logic [WIDTH-1:0] pdata
);

  logic [WIDTH-1:0] sr_q;
  logic [WIDTH-1:0] base;

  // clr together with en loads din into an otherwise empty register.
  always_comb begin
    base = clr ? '0 : sr_q;
    if (MsbFirst) begin
      pdata = {base[WIDTH-2:0], din};
    end else begin
      pdata = {din, base[WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr_q <= '0;
    end else if (tick && en) begin
      sr_q <= pdata;
    end else if (tick && clr) begin
      sr_q <= '0;
    end
  end

endmodule

// File: rtl/serial_frame_receiver.sv
// Receives MSB-first frames framed by soc/SI_en on tick enables and presents each complete word.
module serial_frame_receiver
  import serial_frame_receiver_pkg::*;
#(
  parameter int unsigned WIDTH   = DefaultWidth,
  parameter int unsigned TIMEOUT = 8,
  parameter int unsigned CNT_W   = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tick,
  input  logic             soc,
  input  logic             SI_en,
  input  logic             sdi,
  output logic [WIDTH-1:0] data,
  output logic             data_valid,
  output logic             frame_err,
  output logic             busy
);

  localparam logic [CNT_W-1:0] LastBit    = CNT_W'(WIDTH - 1);
  localparam logic [7:0]       TimeoutCnt = 8'(TIMEOUT);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] bcnt_q, bcnt_d;
  logic [7:0]       tcnt_q, tcnt_d;
  logic [7:0]       tcnt_inc;
  logic [WIDTH-1:0] data_q, data_d;
  logic             dv_q, dv_d;
  logic             err_q, err_d;
  logic             busy_q, busy_d;
  logic             sr_en, sr_clr;
  logic [WIDTH-1:0] sr_pdata;

  sfr_shift_reg #(
    .WIDTH(WIDTH)
  ) u_shift_reg (
    .clk  (clk),
    .rst_n(rst_n),
    .tick (tick),
    .en   (sr_en),
    .clr  (sr_clr),
    .din  (sdi),
    .pdata(sr_pdata)
  );

  assign tcnt_inc = tcnt_q + 8'd1;

  always_comb begin
    state_d = state_q;
    bcnt_d  = bcnt_q;
    tcnt_d  = tcnt_q;
    data_d  = data_q;
    dv_d    = 1'b0;
    err_d   = 1'b0;
    sr_en   = 1'b0;
    sr_clr  = 1'b0;

    if (tick) begin
      unique case (state_q)
        StIdle: begin
          if (soc) begin
            state_d = StArmed;
            tcnt_d  = '0;
          end
        end

        StArmed: begin
          if (SI_en) begin
            sr_clr  = 1'b1;
            sr_en   = 1'b1;
            bcnt_d  = CNT_W'(1);
            state_d = StShift;
          end else if (soc) begin
            tcnt_d = '0;
          end else if (tcnt_inc == TimeoutCnt) begin
            err_d   = 1'b1;
            tcnt_d  = '0;
            state_d = StIdle;
          end else begin
            tcnt_d = tcnt_inc;
          end
        end

        StShift: begin
          if (SI_en && (bcnt_q == LastBit)) begin
            // Final bit wins over a coincident soc; soc then just re-arms.
            sr_en   = 1'b1;
            data_d  = sr_pdata;
            dv_d    = 1'b1;
            bcnt_d  = '0;
            tcnt_d  = '0;
            state_d = soc ? StArmed : StIdle;
          end else if (soc) begin
            err_d   = 1'b1;
            sr_clr  = 1'b1;
            bcnt_d  = '0;
            tcnt_d  = '0;
            state_d = StArmed;
          end else if (!SI_en) begin
            err_d   = 1'b1;
            sr_clr  = 1'b1;
            bcnt_d  = '0;
            state_d = StIdle;
          end else begin
            sr_en  = 1'b1;
            bcnt_d = bcnt_q + CNT_W'(1);
          end
        end

        default: begin
          state_d = StIdle;
          bcnt_d  = '0;
          tcnt_d  = '0;
        end
      endcase
    end

    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      bcnt_q  <= '0;
      tcnt_q  <= '0;
      data_q  <= '0;
      dv_q    <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      bcnt_q  <= bcnt_d;
      tcnt_q  <= tcnt_d;
      data_q  <= data_d;
      dv_q    <= dv_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
    end
  end

  assign data       = data_q;
  assign data_valid = dv_q;
  assign frame_err  = err_q;
  assign busy       = busy_q;

endmodule
